// File: rtl/sp_ram_fifo_ctrl_pkg.sv
// Shared sizing for the FIFO controller and its single-port RAM, plus the arbiter grant encoding.
package sp_ram_fifo_ctrl_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/sp_ram_fifo_ctrl.sv
// Valid/ready FIFO over one single-port RAM port: one access per cycle, write/read arbitrated by a toggling priority.
// Registered output word prefetched from RAM; push-to-out_valid is 3 cycles, sustained drain is 1 word per 2 cycles.
module sp_ram_fifo_ctrl
  import sp_ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              prio_q, prio_d;
  logic              rdy_en_q, rdy_en_d;

  logic read_req;
  logic write_req;
  gnt_e gnt;

  // Arbiter: read_req deliberately ignores in_valid so in_ready stays a pure function of state.
  always_comb begin
    read_req  = (ram_cnt_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
    write_req = in_valid && (ram_cnt_q != CNT_FULL) && rdy_en_q;
    gnt       = GNT_IDLE;
    prio_d    = prio_q;
    if (read_req && write_req) begin
      gnt    = prio_q ? GNT_RD : GNT_WR;
      prio_d = !prio_q;
    end else if (read_req) begin
      gnt = GNT_RD;
    end else if (write_req) begin
      gnt = GNT_WR;
    end
    in_ready  = rdy_en_q && (ram_cnt_q != CNT_FULL) && !(read_req && prio_q);
    ram_we    = (gnt == GNT_WR);
    ram_addr  = (gnt == GNT_WR) ? wr_ptr_q : rd_ptr_q;
    ram_wdata = in_data;
    rdy_en_d  = 1'b1;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    rd_pend_d = 1'b0;
    if (gnt == GNT_WR) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end else if (gnt == GNT_RD) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q - 1'b1;
      rd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      prio_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      prio_q    <= prio_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  // A read is only issued when the output slot will be free, so capture never overwrites a live word.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (rd_pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rdata;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = ram_cnt_q + (ADDR_W+1)'(rd_pend_q) + (ADDR_W+1)'(out_valid_q);
  assign empty     = (count == '0);
  assign full      = (ram_cnt_q == CNT_FULL);

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Directed bench for sp_ram_fifo_ctrl with a behavioural single-port RAM and an in-order scoreboard.
module tb_sp_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata = 4'h0;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mem[16];

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .empty(empty), .full(full),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept monitor: every handshaken push becomes an expected output word.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(in_data);
      acc_cnt++;
    end
  end

  // Output monitor: every handshaken pop is compared with the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        chk("pop_data", {28'h0, out_data}, {28'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic drain();
    bit done = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      step();
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    out_ready = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    end
    @(negedge clk);
    chk("drained_empty", {31'h0, empty}, 32'd1);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
  endtask

  int prev_acc;
  logic [3:0] wdat;
  bit acc_last;
  int ncyc;
  logic [0:5] we_pat;

  initial begin
    // Reset held with a pending push.
    in_valid = 1'b1;
    in_data  = 4'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'd0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_count", {27'h0, count}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'd1);
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready_edge0", {31'h0, in_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("rel_in_ready_edge1", {31'h0, in_ready}, 32'd1);
    step();

    // Single word: write, read, capture.
    in_valid = 1'b1;
    in_data  = 4'hA;
    @(negedge clk);
    chk("sw_we", {31'h0, ram_we}, 32'd1);
    chk("sw_waddr", {28'h0, ram_addr}, 32'd0);
    chk("sw_wdata", {28'h0, ram_wdata}, 32'hA);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sw_rd_we", {31'h0, ram_we}, 32'd0);
    chk("sw_raddr", {28'h0, ram_addr}, 32'd0);
    chk("sw_count1", {27'h0, count}, 32'd1);
    chk("sw_ov1", {31'h0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("sw_count2", {27'h0, count}, 32'd1);
    chk("sw_ov2", {31'h0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("sw_count3", {27'h0, count}, 32'd1);
    chk("sw_ov3", {31'h0, out_valid}, 32'd1);
    chk("sw_data", {28'h0, out_data}, 32'hA);
    step();
    drain();

    // Fill with the consumer stalled: one word in the output register, sixteen in RAM.
    for (int i = 0; i < 17; i++) push(4'(i));
    prev_acc = acc_cnt;
    in_valid = 1'b1;
    in_data  = 4'h1;
    repeat (3) step();
    @(negedge clk);
    chk("fill_full", {31'h0, full}, 32'd1);
    chk("fill_in_ready", {31'h0, in_ready}, 32'd0);
    chk("fill_count", {27'h0, count}, 32'd17);
    chk("fill_no_extra", acc_cnt - prev_acc, 32'd0);
    step();
    in_valid = 1'b0;
    drain();

    // Contention: eight words held, then push and pop together.
    do_reset();
    for (int i = 0; i < 8; i++) push(4'(i));
    repeat (3) step();
    we_pat = 6'b101101;
    wdat = 4'h8;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = wdat;
      @(negedge clk);
      chk("cont_we", {31'h0, ram_we}, {31'h0, we_pat[c]});
      chk("cont_in_ready", {31'h0, in_ready}, {31'h0, we_pat[c]});
      acc_last = in_ready;
      step();
      if (acc_last) wdat = wdat + 4'h1;
    end
    in_valid = 1'b0;
    drain();

    // Random valid/ready over 40 words; pointers wrap repeatedly.
    prev_acc = acc_cnt;
    wdat = 4'h0;
    in_valid = 1'b0;
    ncyc = 0;
    while ((acc_cnt - prev_acc) < 40 && ncyc < 2000) begin
      if (!in_valid || acc_last) begin
        if (acc_last) wdat = wdat + 4'h3;
        in_valid = ($urandom_range(0, 3) != 0) && ((acc_cnt - prev_acc) < 40);
        in_data  = wdat;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc_last = in_valid && in_ready;
      step();
      ncyc++;
    end
    in_valid = 1'b0;
    chk("wrap_accepted", acc_cnt - prev_acc, 32'd40);
    drain();

    // Reset while a read is in flight.
    do_reset();
    for (int i = 0; i < 6; i++) push(4'(i + 9));
    repeat (2) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("mid_count_before", {27'h0, count}, 32'd5);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_count_async", {27'h0, count}, 32'd0);
    chk("mid_ov_async", {31'h0, out_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    push(4'h3);
    prev_acc = checks;
    drain();
    chk("mid_first_pop_seen", (checks - prev_acc) >= 2 ? 32'd1 : 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got time limit expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
